// File: rtl/bpsk_mod_pkg.sv
// Shared definitions for the BPSK modulator: default sizes, FSM state type
// and the saturating negate used by the symbol mapper.
package bpsk_mod_pkg;

  localparam int WIDTH_DEF = 10;
  localparam int SPS_DEF   = 16;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Negate a sign-extended w-bit value, clamping the single overflow case
  // (-2^(w-1)) to the largest positive w-bit value.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                 input int w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (x < -lim) begin
      sat_neg = lim;
    end else begin
      sat_neg = -x;
    end
  endfunction

endpackage

// File: rtl/bpsk_sym_mapper.sv
// Combinational symbol mapper: differential encode of the incoming bit and
// +/-1 multiply of the carrier with saturation on the negated path.
module bpsk_sym_mapper
  import bpsk_mod_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             bit_i,      // raw data bit at a boundary
  input  logic             diff_en_i,  // differential encoding enable
  input  logic             diff_i,     // previous encoded symbol
  input  logic             load_i,     // this sample starts a new symbol
  input  logic             cur_i,      // symbol currently being held
  input  logic             zero_i,     // force a zero output sample
  input  logic [WIDTH-1:0] carrier_i,
  output logic             enc_o,      // encoded symbol to be stored
  output logic [WIDTH-1:0] mod_o
);

  logic             sym;
  logic [WIDTH-1:0] neg;

  assign enc_o = diff_en_i ? (bit_i ^ diff_i) : bit_i;

  // A freshly loaded symbol applies to the very sample that loads it.
  assign sym = load_i ? enc_o : cur_i;

  assign neg = WIDTH'(sat_neg({{(32 - WIDTH){carrier_i[WIDTH-1]}}, carrier_i}, WIDTH));

  assign mod_o = zero_i ? '0 : (sym ? neg : carrier_i);

endmodule

// File: rtl/bpsk_mod.sv
// BPSK modulator: holds each data bit for SPS carrier samples, optionally
// differentially encodes it and flips the carrier sign for a '1' symbol.
module bpsk_mod
  import bpsk_mod_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SPS   = SPS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clken,
  input  logic [WIDTH-1:0] carrier_i,
  input  logic             carrier_valid_i,
  input  logic             diff_en_i,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  output logic             bit_ready_o,
  output logic [WIDTH-1:0] mod_o,
  output logic             mod_valid_o,
  output logic             sym_strobe_o,
  output logic             underflow_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             hold_full_q, hold_full_d;
  logic             hold_bit_q,  hold_bit_d;
  logic             diff_q,      diff_d;
  logic             cur_q,       cur_d;
  logic [WIDTH-1:0] mod_q,       mod_d;
  logic             mod_valid_q, mod_valid_d;
  logic             strobe_q,    strobe_d;
  logic             underflow_q, underflow_d;

  logic             tick;
  logic             accept;
  logic             boundary;
  logic             bit_avail;
  logic             new_bit;
  logic             load;
  logic             starve;
  logic             enc;
  logic [WIDTH-1:0] mapped;

  assign tick      = clken & carrier_valid_i;
  assign accept    = clken & bit_valid_i & ~hold_full_q;
  assign boundary  = tick & ((state_q == IDLE) | (cnt_q == CNT_LAST));
  // With the hold register empty, a valid bit_i is taken straight through.
  assign bit_avail = hold_full_q | bit_valid_i;
  assign new_bit   = hold_full_q ? hold_bit_q : bit_i;
  assign load      = boundary & bit_avail;
  assign starve    = boundary & ~bit_avail;

  assign bit_ready_o  = ~hold_full_q;
  assign mod_o        = mod_q;
  assign mod_valid_o  = mod_valid_q;
  assign sym_strobe_o = strobe_q;
  assign underflow_o  = underflow_q;

  bpsk_sym_mapper #(
    .WIDTH(WIDTH)
  ) u_mapper (
    .bit_i     (new_bit),
    .diff_en_i (diff_en_i),
    .diff_i    (diff_q),
    .load_i    (load),
    .cur_i     (cur_q),
    .zero_i    (starve),
    .carrier_i (carrier_i),
    .enc_o     (enc),
    .mod_o     (mapped)
  );

  // Next-state logic: symbol FSM, sample counter, hold register and outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;
    hold_bit_d  = hold_bit_q;
    diff_d      = diff_q;
    cur_d       = cur_q;
    mod_d       = mod_q;
    mod_valid_d = mod_valid_q;
    strobe_d    = strobe_q;
    underflow_d = underflow_q;

    if (load) begin
      state_d = RUN;
      cnt_d   = '0;
      diff_d  = enc;
      cur_d   = enc;
    end else if (starve) begin
      if (state_q == RUN) begin
        state_d = IDLE;
        diff_d  = 1'b0;
      end
    end else if (tick && (state_q == RUN)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // An accept coinciding with a boundary can only be the bypass case,
    // since a full hold register keeps ready low.
    if (boundary && hold_full_q) begin
      hold_full_d = 1'b0;
    end else if (accept && !boundary) begin
      hold_full_d = 1'b1;
      hold_bit_d  = bit_i;
    end

    if (clken) begin
      mod_valid_d = carrier_valid_i;
      strobe_d    = load;
      underflow_d = starve & (state_q == RUN);
      if (tick) begin
        mod_d = mapped;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      hold_bit_q  <= 1'b0;
      diff_q      <= 1'b0;
      cur_q       <= 1'b0;
      mod_q       <= '0;
      mod_valid_q <= 1'b0;
      strobe_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      hold_bit_q  <= hold_bit_d;
      diff_q      <= diff_d;
      cur_q       <= cur_d;
      mod_q       <= mod_d;
      mod_valid_q <= mod_valid_d;
      strobe_q    <= strobe_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_bpsk_mod.sv
// Randomized self-checking bench for bpsk_mod against a sample-level model.
module tb_bpsk_mod;

  localparam int WIDTH = 10;
  localparam int SPS   = 16;
  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << (WIDTH - 1)) - 1;
  localparam int MINV  = -(1 << (WIDTH - 1));

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clken;
  logic [WIDTH-1:0] carrier_i;
  logic             carrier_valid_i;
  logic             diff_en_i;
  logic             bit_i;
  logic             bit_valid_i;
  logic             bit_ready_o;
  logic [WIDTH-1:0] mod_o;
  logic             mod_valid_o;
  logic             sym_strobe_o;
  logic             underflow_o;

  bpsk_mod #(
    .WIDTH(WIDTH),
    .SPS  (SPS),
    .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clken          (clken),
    .carrier_i      (carrier_i),
    .carrier_valid_i(carrier_valid_i),
    .diff_en_i      (diff_en_i),
    .bit_i          (bit_i),
    .bit_valid_i    (bit_valid_i),
    .bit_ready_o    (bit_ready_o),
    .mod_o          (mod_o),
    .mod_valid_o    (mod_valid_o),
    .sym_strobe_o   (sym_strobe_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: symbol stream view of the modulator.
  bit m_run;        // a symbol is being transmitted
  int m_cnt;        // index of the current sample within its symbol
  bit m_diff;       // last transmitted (encoded) symbol, for differential mode
  bit m_sym;        // symbol applied to the current samples
  bit pend[$];      // bits accepted but not yet started (at most one)
  bit tx[$];        // bits the bench still wants to send

  int e_mod;
  bit e_valid, e_strobe, e_uf;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int shape(input int c, input bit s);
    if (!s) return c;
    return (-c > MAXV) ? MAXV : -c;
  endfunction

  task automatic check_outputs();
    check_eq("mod_o",        $signed(mod_o), e_mod);
    check_eq("mod_valid_o",  mod_valid_o,    e_valid);
    check_eq("sym_strobe_o", sym_strobe_o,   e_strobe);
    check_eq("underflow_o",  underflow_o,    e_uf);
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_diff = 0; m_sym = 0;
    pend.delete();
    e_mod = 0; e_valid = 0; e_strobe = 0; e_uf = 0;
  endtask

  // One clock cycle: drive inputs, advance the model, then check the
  // registered outputs just after the edge.
  task automatic cycle(input bit cv, input bit ce, input bit den);
    int c;
    bit ready_m, acc, bnd, b, d, bypassed;
    c = ($urandom_range(0, 5) == 0) ? MINV : (int'($urandom_range(0, 1023)) + MINV);
    clken           = ce;
    carrier_valid_i = cv;
    diff_en_i       = den;
    carrier_i       = c[WIDTH-1:0];
    bit_valid_i     = (tx.size() > 0);
    bit_i           = (tx.size() > 0) ? tx[0] : 1'($urandom);

    ready_m  = (pend.size() == 0);
    check_eq("bit_ready_o", bit_ready_o, ready_m);
    acc      = ce && bit_valid_i && ready_m;
    bypassed = 0;

    if (ce) begin
      e_valid  = cv;
      e_strobe = 0;
      e_uf     = 0;
      if (cv) begin
        bnd = !m_run || (m_cnt == SPS - 1);
        if (bnd && (pend.size() > 0 || bit_valid_i)) begin
          if (pend.size() > 0) begin
            b = pend.pop_front();
          end else begin
            b = bit_i;
            bypassed = 1;
          end
          d = den ? (b ^ m_diff) : b;
          m_diff = d; m_sym = d; m_run = 1; m_cnt = 0;
          e_mod = shape(c, d);
          e_strobe = 1;
        end else if (bnd) begin
          e_uf = m_run;
          m_run = 0; m_diff = 0;
          e_mod = 0;
        end else begin
          m_cnt++;
          e_mod = shape(c, m_sym);
        end
      end
      if (acc && !bypassed) pend.push_back(bit_i);
    end

    if (acc) begin
      $display("bit %0d accepted (%s) t=%0t", bit_i, bypassed ? "bypass" : "held", $time);
      void'(tx.pop_front());
    end

    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    clken = 0; carrier_valid_i = 0; bit_valid_i = 0;
    reset_n = 0;
    #2;
    model_reset();
    check_outputs();
    check_eq("reset_ready", bit_ready_o, 1);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1; clken = 0; carrier_valid_i = 0; diff_en_i = 0;
    bit_i = 0; bit_valid_i = 0; carrier_i = '0;
    #1;
    do_reset();

    // Continuous carrier, no bits: valid zeros only.
    for (int i = 0; i < 40; i++) cycle(1, 1, 0);
    cycle(0, 1, 0);
    cycle(1, 1, 0);

    // Two plain bits then starvation, later restart.
    tx = '{0, 1};
    for (int i = 0; i < 45; i++) cycle(1, 1, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0);
    tx = '{1};
    for (int i = 0; i < 20; i++) cycle(1, 1, 1);

    // Differential encoding: 1,1,0,0 -> 1,0,0,0.
    for (int i = 0; i < 5; i++) cycle(1, 1, 1);
    tx = '{1, 1, 0, 0};
    for (int i = 0; i < 80; i++) cycle(1, 1, 1);

    // Gapped carrier and toggled clock enable with a random bit stream.
    for (int i = 0; i < 700; i++) begin
      if (tx.size() < 2 && $urandom_range(0, 9) != 0) tx.push_back(1'($urandom));
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
    end

    // Reset at sample 7 of a symbol with the hold register full.
    tx.delete();
    for (int i = 0; i < 20; i++) cycle(1, 1, 0);
    tx = '{1, 0, 1};
    for (int i = 0; i < 8; i++) cycle(1, 1, 0);
    do_reset();
    for (int i = 0; i < 40; i++) cycle(1, 1, 0);

    // Free-running random mix.
    for (int i = 0; i < 600; i++) begin
      if (tx.size() < 2 && $urandom_range(0, 7) != 0) tx.push_back(1'($urandom));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
